// File: rtl/rx_frame_monitor.sv
// -----------------------------------------------------------------------------
// rx_frame_monitor
//
// Receive-side statistics collector for the 10G MAC receive client interface,
// running entirely on the 156.25 MHz MAC clock. It measures every frame from
// its per-beat byte-valid lanes and classifies it on the end-of-frame strobe.
// The results are published through an atomic snapshot-and-clear.
//
// Parameters
//   RUNT_LEN      frames shorter than this are runts
//   MAX_STD_LEN   frames longer than this are jumbo
//   CNT_W         width of every frame counter
//
// Ports
//   clk156         in   MAC receive clock
//   reset_n        in   asynchronous active-low reset
//   rx_data        in   receive data (observed only, never interpreted)
//   rx_data_valid  in   per-byte valid, lane 0 = bits 7:0
//   rx_good_frame  in   end-of-frame strobe, frame good
//   rx_bad_frame   in   end-of-frame strobe, frame bad (wins over good)
//   snap_req       in   pulse: snapshot live counters and clear them
//   snap_ack       out  pulse one cycle after the snapshot edge
//   good_frames    out  snapshot good-frame count
//   bad_frames     out  snapshot bad-frame count
//   good_bytes     out  snapshot sum of good-frame lengths
//   runt_frames    out  snapshot runt count (good or bad)
//   jumbo_frames   out  snapshot jumbo count (good or bad)
//   max_frame_len  out  snapshot largest good-frame length
//   mon_data       out  registered rx_data
//   mon_valid      out  registered rx_data_valid
// -----------------------------------------------------------------------------
module rx_frame_monitor #(
    parameter int RUNT_LEN    = 64,
    parameter int MAX_STD_LEN = 1518,
    parameter int CNT_W       = 32
) (
    input  logic             clk156,
    input  logic             reset_n,
    input  logic [63:0]      rx_data,
    input  logic [7:0]       rx_data_valid,
    input  logic             rx_good_frame,
    input  logic             rx_bad_frame,
    input  logic             snap_req,
    output logic             snap_ack,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames,
    output logic [47:0]      good_bytes,
    output logic [CNT_W-1:0] runt_frames,
    output logic [CNT_W-1:0] jumbo_frames,
    output logic [15:0]      max_frame_len,
    output logic [63:0]      mon_data,
    output logic [7:0]       mon_valid
);

    localparam logic [15:0]      RUNT_LEN_C    = 16'(RUNT_LEN);
    localparam logic [15:0]      MAX_STD_LEN_C = 16'(MAX_STD_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};

    // Number of set bits in a byte-valid vector. Any pattern is counted,
    // so an illegal non-contiguous valid still contributes its lane count.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // 16-bit length plus a beat byte count, pinned at 0xFFFF instead of
    // wrapping so an oversize frame still reads as "very long".
    function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                              input logic [3:0]  b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Stage-1 registers (mon_data / mon_valid double as the data/valid stage)
    logic             good_r;
    logic             bad_r;
    logic             snap_r;

    // Frame-length accumulator and live counters
    logic [15:0]      acc_r;
    logic [CNT_W-1:0] good_cnt_r;
    logic [CNT_W-1:0] bad_cnt_r;
    logic [47:0]      good_bytes_r;
    logic [CNT_W-1:0] runt_cnt_r;
    logic [CNT_W-1:0] jumbo_cnt_r;
    logic [15:0]      max_len_r;
    logic             snap_d_r;

    // Combinational next values
    logic [3:0]       beat_bytes_s;
    logic [15:0]      frame_len_s;
    logic             eof_s;
    logic [15:0]      acc_nx_s;
    logic [CNT_W-1:0] good_cnt_nx_s;
    logic [CNT_W-1:0] bad_cnt_nx_s;
    logic [47:0]      good_bytes_nx_s;
    logic [CNT_W-1:0] runt_cnt_nx_s;
    logic [CNT_W-1:0] jumbo_cnt_nx_s;
    logic [15:0]      max_len_nx_s;

    // Stage 1: register every MAC input
    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            mon_data  <= 64'd0;
            mon_valid <= 8'd0;
            good_r    <= 1'b0;
            bad_r     <= 1'b0;
            snap_r    <= 1'b0;
        end else begin
            mon_data  <= rx_data;
            mon_valid <= rx_data_valid;
            good_r    <= rx_good_frame;
            bad_r     <= rx_bad_frame;
            snap_r    <= snap_req;
        end
    end

    // Beat size and the running frame length including this beat. The MAC
    // never starts a new frame in a strobe cycle, so on a strobe the whole
    // sum belongs to the ending frame.
    always_comb begin
        beat_bytes_s = popcount8(mon_valid);
        frame_len_s  = sat_add16(acc_r, beat_bytes_s);
        eof_s        = good_r | bad_r;
    end

    // Next accumulator and live-counter values, including classification
    // of a frame ending this cycle
    always_comb begin
        acc_nx_s        = frame_len_s;
        good_cnt_nx_s   = good_cnt_r;
        bad_cnt_nx_s    = bad_cnt_r;
        good_bytes_nx_s = good_bytes_r;
        runt_cnt_nx_s   = runt_cnt_r;
        jumbo_cnt_nx_s  = jumbo_cnt_r;
        max_len_nx_s    = max_len_r;
        if (eof_s) begin
            acc_nx_s = 16'd0;
            // A bad strobe overrides a simultaneous good strobe
            if (bad_r) begin
                bad_cnt_nx_s = bad_cnt_r + CNT_ONE;
            end else begin
                good_cnt_nx_s   = good_cnt_r + CNT_ONE;
                good_bytes_nx_s = good_bytes_r + {32'd0, frame_len_s};
                if (frame_len_s > max_len_r) begin
                    max_len_nx_s = frame_len_s;
                end else begin
                    max_len_nx_s = max_len_r;
                end
            end
            // Size classes apply to good and bad frames alike
            if (frame_len_s < RUNT_LEN_C) begin
                runt_cnt_nx_s = runt_cnt_r + CNT_ONE;
            end else begin
                runt_cnt_nx_s = runt_cnt_r;
            end
            if (frame_len_s > MAX_STD_LEN_C) begin
                jumbo_cnt_nx_s = jumbo_cnt_r + CNT_ONE;
            end else begin
                jumbo_cnt_nx_s = jumbo_cnt_r;
            end
        end else begin
            acc_nx_s = frame_len_s;
        end
    end

    // Live counters, snapshot registers and acknowledge. A snapshot takes
    // the next values so a frame committing on the same edge is included,
    // while the accumulator keeps running so an in-flight frame is counted
    // whole in the following interval.
    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            acc_r         <= 16'd0;
            good_cnt_r    <= CNT_ZERO;
            bad_cnt_r     <= CNT_ZERO;
            good_bytes_r  <= 48'd0;
            runt_cnt_r    <= CNT_ZERO;
            jumbo_cnt_r   <= CNT_ZERO;
            max_len_r     <= 16'd0;
            good_frames   <= CNT_ZERO;
            bad_frames    <= CNT_ZERO;
            good_bytes    <= 48'd0;
            runt_frames   <= CNT_ZERO;
            jumbo_frames  <= CNT_ZERO;
            max_frame_len <= 16'd0;
            snap_d_r      <= 1'b0;
            snap_ack      <= 1'b0;
        end else begin
            acc_r    <= acc_nx_s;
            snap_d_r <= snap_r;
            snap_ack <= snap_d_r;
            if (snap_r) begin
                good_frames   <= good_cnt_nx_s;
                bad_frames    <= bad_cnt_nx_s;
                good_bytes    <= good_bytes_nx_s;
                runt_frames   <= runt_cnt_nx_s;
                jumbo_frames  <= jumbo_cnt_nx_s;
                max_frame_len <= max_len_nx_s;
                good_cnt_r    <= CNT_ZERO;
                bad_cnt_r     <= CNT_ZERO;
                good_bytes_r  <= 48'd0;
                runt_cnt_r    <= CNT_ZERO;
                jumbo_cnt_r   <= CNT_ZERO;
                max_len_r     <= 16'd0;
            end else begin
                good_cnt_r    <= good_cnt_nx_s;
                bad_cnt_r     <= bad_cnt_nx_s;
                good_bytes_r  <= good_bytes_nx_s;
                runt_cnt_r    <= runt_cnt_nx_s;
                jumbo_cnt_r   <= jumbo_cnt_nx_s;
                max_len_r     <= max_len_nx_s;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_monitor.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_monitor
//
// Directed bench for rx_frame_monitor. Each task drives one scenario and
// checks the snapshot outputs against hand-computed values. The snapshot
// outputs are compared as one packed vector
// {good, bad, bytes, runt, jumbo, max}.
// -----------------------------------------------------------------------------
module tb_rx_frame_monitor;

    logic        clk156;
    logic        reset_n;
    logic [63:0] rx_data;
    logic [7:0]  rx_data_valid;
    logic        rx_good_frame;
    logic        rx_bad_frame;
    logic        snap_req;
    logic        snap_ack;
    logic [31:0] good_frames;
    logic [31:0] bad_frames;
    logic [47:0] good_bytes;
    logic [31:0] runt_frames;
    logic [31:0] jumbo_frames;
    logic [15:0] max_frame_len;
    logic [63:0] mon_data;
    logic [7:0]  mon_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [191:0] snap_vec;
    logic [191:0] exp_vec;
    logic [3:0]   ack_hist;

    assign snap_vec = {good_frames, bad_frames, good_bytes,
                       runt_frames, jumbo_frames, max_frame_len};

    rx_frame_monitor #(
        .RUNT_LEN    (64),
        .MAX_STD_LEN (1518),
        .CNT_W       (32)
    ) dut (
        .clk156        (clk156),
        .reset_n       (reset_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_good_frame (rx_good_frame),
        .rx_bad_frame  (rx_bad_frame),
        .snap_req      (snap_req),
        .snap_ack      (snap_ack),
        .good_frames   (good_frames),
        .bad_frames    (bad_frames),
        .good_bytes    (good_bytes),
        .runt_frames   (runt_frames),
        .jumbo_frames  (jumbo_frames),
        .max_frame_len (max_frame_len),
        .mon_data      (mon_data),
        .mon_valid     (mon_valid)
    );

    initial clk156 = 1'b0;
    always #5 clk156 = ~clk156;

    function automatic string fmt(input logic [191:0] v);
        return $sformatf("good=%0d bad=%0d bytes=%0d runt=%0d jumbo=%0d max=%0d",
                         v[191:160], v[159:128], v[127:80], v[79:48], v[47:16], v[15:0]);
    endfunction

    // One beat: inputs applied, then one clock edge, returning 1 time unit later
    task automatic drive(input logic [7:0] v, input logic g, input logic b, input logic s);
        rx_data       = {$urandom, $urandom};
        rx_data_valid = v;
        rx_good_frame = g;
        rx_bad_frame  = b;
        snap_req      = s;
        @(posedge clk156);
        #1;
    endtask

    // Snapshot request on an idle beat, recording snap_ack after each of the
    // following four edges. Outputs are valid from hist[1] onward.
    task automatic take_snap(output logic [3:0] hist);
        drive(8'h00, 1'b0, 1'b0, 1'b1); hist[0] = snap_ack;
        drive(8'h00, 1'b0, 1'b0, 1'b0); hist[1] = snap_ack;
        drive(8'h00, 1'b0, 1'b0, 1'b0); hist[2] = snap_ack;
        drive(8'h00, 1'b0, 1'b0, 1'b0); hist[3] = snap_ack;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        rx_data       = 64'hA5A5_5A5A_DEAD_BEEF;
        rx_data_valid = 8'hFF;
        rx_good_frame = 1'b1;
        rx_bad_frame  = 1'b0;
        snap_req      = 1'b1;
        repeat (3) @(posedge clk156);
        #1;
        tests_run++;
        if ({snap_vec, snap_ack, mon_data, mon_valid} !== 265'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %s ack=%0b mon=%h/%h, expected all zero",
                     fmt(snap_vec), snap_ack, mon_data, mon_valid);
        end
        rx_data_valid = 8'h00;
        rx_good_frame = 1'b0;
        snap_req      = 1'b0;
        reset_n       = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_monitor();
        rx_data       = 64'h0123_4567_89AB_CDEF;
        rx_data_valid = 8'h03;
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
        snap_req      = 1'b0;
        @(posedge clk156);
        #1;
        tests_run++;
        if ({mon_data, mon_valid} !== {64'h0123_4567_89AB_CDEF, 8'h03}) begin
            tests_failed++;
            $display("FAIL monitor_path: got %h/%h, expected 0123456789abcdef/03",
                     mon_data, mon_valid);
        end
        // 2-byte frame closed by a bad strobe on an idle beat
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        take_snap(ack_hist);
        exp_vec = {32'd0, 32'd1, 48'd0, 32'd1, 32'd0, 16'd0};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL bad_2byte: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
        // Good strobe with no data: zero length, counts as runt
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        take_snap(ack_hist);
        exp_vec = {32'd1, 32'd0, 48'd0, 32'd1, 32'd0, 16'd0};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL zero_len: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
    endtask

    task automatic test_good_64();
        for (int i = 0; i < 8; i++) begin
            drive(8'hFF, (i == 7), 1'b0, 1'b0);
        end
        take_snap(ack_hist);
        exp_vec = {32'd1, 32'd0, 48'd64, 32'd0, 32'd0, 16'd64};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL good_64: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
        tests_run++;
        if (ack_hist !== 4'b0100) begin
            tests_failed++;
            $display("FAIL snap_ack_pulse: got %b, expected 0100", ack_hist);
        end
    endtask

    task automatic test_runt_jumbo();
        // 60 bytes, strobe after two idle beats
        for (int i = 0; i < 7; i++) drive(8'hFF, 1'b0, 1'b0, 1'b0);
        drive(8'h0F, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        // Outputs must still hold the previous snapshot
        exp_vec = {32'd1, 32'd0, 48'd64, 32'd0, 32'd0, 16'd64};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL snap_stable: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
        take_snap(ack_hist);
        exp_vec = {32'd1, 32'd0, 48'd60, 32'd1, 32'd0, 16'd60};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL runt_60: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
        // 1518 bytes (not jumbo) then 1519 bytes (jumbo)
        for (int i = 0; i < 189; i++) drive(8'hFF, 1'b0, 1'b0, 1'b0);
        drive(8'h3F, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 189; i++) drive(8'hFF, 1'b0, 1'b0, 1'b0);
        drive(8'h7F, 1'b1, 1'b0, 1'b0);
        take_snap(ack_hist);
        exp_vec = {32'd2, 32'd0, 48'd3037, 32'd0, 32'd1, 16'd1519};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL jumbo_1519: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
    endtask

    task automatic test_good_and_bad();
        for (int i = 0; i < 12; i++) drive(8'hFF, 1'b0, 1'b0, 1'b0);
        drive(8'h0F, 1'b1, 1'b1, 1'b0);
        take_snap(ack_hist);
        exp_vec = {32'd0, 32'd1, 48'd0, 32'd0, 32'd0, 16'd0};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL good_and_bad: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
    endtask

    task automatic test_snap_same_cycle();
        for (int i = 0; i < 8; i++) drive(8'hFF, 1'b0, 1'b0, 1'b0);
        drive(8'hFF, 1'b1, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        exp_vec = {32'd1, 32'd0, 48'd72, 32'd0, 32'd0, 16'd72};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL snap_same_cycle: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (snap_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL snap_same_ack: got %0b, expected 1", snap_ack);
        end
        take_snap(ack_hist);
        tests_run++;
        if (snap_vec !== 192'd0) begin
            tests_failed++;
            $display("FAIL snap_cleared: got %s, expected all zero", fmt(snap_vec));
        end
    endtask

    task automatic test_snap_window();
        // 8-byte frame, then a 72-byte frame whose strobe lands one edge
        // after the snapshot request: only the first frame is captured
        drive(8'hFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(8'hFF, 1'b0, 1'b0, 1'b0);
        drive(8'hFF, 1'b0, 1'b0, 1'b1);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        exp_vec = {32'd1, 32'd0, 48'd8, 32'd1, 32'd0, 16'd8};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL window_excl: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
        take_snap(ack_hist);
        exp_vec = {32'd1, 32'd0, 48'd72, 32'd0, 32'd0, 16'd72};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL window_next: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
    endtask

    task automatic test_back_to_back();
        drive(8'hFF, 1'b1, 1'b0, 1'b0);
        drive(8'h01, 1'b0, 1'b1, 1'b0);
        drive(8'h03, 1'b1, 1'b0, 1'b0);
        take_snap(ack_hist);
        exp_vec = {32'd2, 32'd1, 48'd10, 32'd3, 32'd0, 16'd8};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL back_to_back: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9000; i++) drive(8'hFF, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        take_snap(ack_hist);
        exp_vec = {32'd1, 32'd0, 48'd65535, 32'd0, 32'd1, 16'hFFFF};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL len_saturation: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 3; i++) drive(8'hFF, 1'b0, 1'b0, 1'b0);
        rx_data       = 64'hFEED_FACE_CAFE_F00D;
        rx_data_valid = 8'hFF;
        reset_n       = 1'b0;
        #1;
        tests_run++;
        if ({snap_vec, snap_ack, mon_data, mon_valid} !== 265'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got %s ack=%0b mon=%h/%h, expected all zero",
                     fmt(snap_vec), snap_ack, mon_data, mon_valid);
        end
        repeat (3) @(posedge clk156);
        #1;
        tests_run++;
        if ({snap_vec, snap_ack, mon_data, mon_valid} !== 265'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: got %s ack=%0b mon=%h/%h, expected all zero",
                     fmt(snap_vec), snap_ack, mon_data, mon_valid);
        end
        rx_data_valid = 8'h00;
        reset_n       = 1'b1;
        drive(8'hFF, 1'b0, 1'b0, 1'b0);
        drive(8'hFF, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        take_snap(ack_hist);
        exp_vec = {32'd1, 32'd0, 48'd16, 32'd1, 32'd0, 16'd16};
        tests_run++;
        if (snap_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL reset_mid_frame: got %s, expected %s", fmt(snap_vec), fmt(exp_vec));
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        rx_data       = 64'd0;
        rx_data_valid = 8'h00;
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
        snap_req      = 1'b0;
        test_reset();
        test_monitor();
        test_good_64();
        test_runt_jumbo();
        test_good_and_bad();
        test_snap_same_cycle();
        test_snap_window();
        test_back_to_back();
        test_saturation();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rx_frame_monitor.md
# rx_frame_monitor

Receive-side statistics collector on the 156.25 MHz XGMII/MAC clock domain. Sits directly downstream of the 10G MAC receive client interface, consuming per-beat data-valid lanes and end-of-frame good/bad strobes. Produces frame, byte, runt, jumbo and max-length statistics. An atomic snapshot-and-clear makes them readable by the chipscope/monitor logic and the LED/status fabric.

## Interface
- `RUNT_LEN`, 64: frames with length strictly below this are counted as runts.
- `MAX_STD_LEN`, 1518: frames with length strictly above this are counted as jumbo.
- `CNT_W`, 32: width of every frame counter.
- `clk156`  in  1  156.25 MHz MAC receive clock; the only clock.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `rx_data`  in  64  MAC receive data. Not interpreted; registered for observability only.
- `rx_data_valid`  in  8  Per-byte valid, lane 0 = bits 7:0. Legal values: 0x00, 0x01, 0x03 … 0xFF.
- `rx_good_frame`  in  1  One-cycle end-of-frame strobe, frame good.
- `rx_bad_frame`  in  1  One-cycle end-of-frame strobe, frame bad.
- `snap_req`  in  1  One-cycle pulse: copy live counters to snapshot outputs and clear them.
- `snap_ack`  out  1  One-cycle pulse, one cycle after the snapshot edge.
- `good_frames`  out  CNT_W  Snapshot count of good frames.
- `bad_frames`  out  CNT_W  Snapshot count of bad frames.
- `good_bytes`  out  48  Snapshot sum of good-frame lengths.
- `runt_frames`  out  CNT_W  Snapshot count of frames (good or bad) with length < RUNT_LEN.
- `jumbo_frames`  out  CNT_W  Snapshot count of frames (good or bad) with length > MAX_STD_LEN.
- `max_frame_len`  out  16  Snapshot of the largest good-frame length.
- `mon_data`  out  64  Registered copy of `rx_data`.
- `mon_valid`  out  8  Registered copy of `rx_data_valid`.

## Operation
- **Stage 1 (input register):** `rx_data`, `rx_data_valid`, `rx_good_frame`, `rx_bad_frame` and `snap_req` are registered. `mon_data`/`mon_valid` are these registers.
- **Beat byte count:** beat bytes = popcount of the registered valid, range 0–8. Popcount is used for any pattern, legal or not.
- **Frame length accumulation:** the 16-bit accumulator `acc` adds beat bytes each cycle and saturates at 0xFFFF.
- **End-of-frame cycle:** on a registered strobe, frame length L = sat16(`acc` + beat bytes of the same cycle), and `acc` clears to 0.
  - The end-of-frame strobe may coincide with the last data beat, or follow it with idle beats (valid 0x00) in between.
  - The MAC guarantees no next-frame beat arrives in the strobe cycle.
- **Classification of a frame of length L:**
  - Good only: `good_frames`+1, `good_bytes`+L, `max_frame_len` = max(current, L).
  - Bad (including good and bad asserted together; bad wins): `bad_frames`+1 only; good counters unchanged.
  - Any frame (good or bad): L < RUNT_LEN → `runt_frames`+1; L > MAX_STD_LEN → `jumbo_frames`+1.
  - L = 0 (strobe with no data) counts as a runt.
- **Counter arithmetic:** frame counters and `good_bytes` wrap modulo 2^width. There is no saturation on counters.
- **Snapshot (registered `snap_req`):**
  - Snapshot outputs load the live value *including* any frame update committing on the same edge.
  - Live counters, including live max length, clear to 0 on the same edge.
  - The frame-length accumulator is not affected, so a frame in flight is counted in full in the next interval.
- **Reset (`reset_n` low, at any time, including mid-frame):** all registers, live counters, snapshot outputs, `acc`, `snap_ack`, `mon_*` → 0. A frame partially received before reset release is measured only from bytes after release.

## Timing
- **Input sampling:** inputs are sampled at edge N (stage 1).
- **Counter and accumulator update:** live counters and `acc` update at edge N+1.
- **Snapshot latency:** with `snap_req` high at edge N, snapshot outputs are valid after edge N+1 and `snap_ack` is high for the cycle following edge N+2.
- **Strobe-to-snapshot window:** a frame strobe at edge N is included in a snapshot whose `snap_req` is sampled at edge ≥ N. A snapshot requested at edge N−1 excludes it.
- **Monitor path:** `mon_data`/`mon_valid` latency is 1 cycle.
- **Throughput:** one frame end per cycle is accepted; back-to-back strobes on consecutive cycles are each counted.
- **Snapshot output stability:** snapshot outputs are stable between snapshots; they change only at the snapshot edge or reset.

## Test plan
- **64-byte good frame:** 8 beats of valid 0xFF, good strobe with the 8th beat, then snapshot → `good_frames`=1, `good_bytes`=64, `max_frame_len`=64, `runt_frames`=0, `jumbo_frames`=0, `snap_ack` single pulse 2 cycles after `snap_req`.
- **Partial last beat and delayed strobe:** 60 bytes (7×0xFF + 0x0F), strobe 2 idle cycles after the last beat → `runt_frames`=1, `good_bytes`=60. Then a 1519-byte frame (189×0xFF + 0x7F) → `jumbo_frames`=1, `max_frame_len`=1519.
- **Simultaneous good and bad:** one 100-byte frame with both strobes asserted together → `bad_frames`=1, `good_frames`=0, `good_bytes`=0.
- **Snapshot/strobe same cycle:** `snap_req` and good strobe of a 72-byte frame in the same cycle → snapshot shows `good_frames`=1. The next snapshot with no traffic shows all zeros.
- **Length saturation:** 9000 beats of 0xFF then good strobe → `max_frame_len`=0xFFFF, `good_bytes`=65535.
- **Reset mid-frame:** `reset_n` low for 3 cycles during beat 4 of a frame; all outputs are 0 during reset. After release, 2 more beats of 0xFF and a good strobe → `good_bytes`=16.
